// File: rtl/iccm_dump_tx.sv
`default_nettype none
// ==========================================================================
// Module : iccm_dump_tx
// Reads a run of ICCM words and streams each as four little-endian 8N1
// bytes on tx_o. Define ICCM_DUMP_CHECKSUM_EN to append an XOR checksum byte.
// Rev    : 1.0
// ==========================================================================
module iccm_dump_tx #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [CNT_WIDTH-1:0]  word_cnt_i,
  input  logic [15:0]           clks_per_bit_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [31:0]           rd_data_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5,
`ifdef ICCM_DUMP_CHECKSUM_EN
    S_CSUM  = 3'd6,
`endif
    S_DONE  = 3'd7
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [15:0]           cpb_q, cpb_d;
  logic [15:0]           tmr_q, tmr_d;
  logic [3:0]            bit_q, bit_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           word_q, word_d;
  logic                  bit_end;
  logic [15:0]           tmr_next;

`ifdef ICCM_DUMP_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
  logic [2:0]            csum_sel;
  assign csum_sel = 3'(bit_q - 4'd1);
`endif

  // cpb_q is never 0, so the subtraction cannot wrap.
  assign bit_end   = (tmr_q == cpb_q - 16'd1);
  assign tmr_next  = bit_end ? 16'd0 : tmr_q + 16'd1;
  assign rd_addr_o = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    cpb_d   = cpb_q;
    tmr_d   = 16'd0;
    bit_d   = bit_q;
    idx_d   = idx_q;
    word_d  = word_q;
`ifdef ICCM_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    rd_en_o = 1'b0;
    tx_o    = 1'b1;
    busy_o  = 1'b1;
    done_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          addr_d  = start_addr_i;
          cnt_d   = word_cnt_i;
          cpb_d   = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
`ifdef ICCM_DUMP_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = (word_cnt_i == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        rd_en_o = 1'b1;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        word_d  = rd_data_i;
        idx_d   = 2'd0;
`ifdef ICCM_DUMP_CHECKSUM_EN
        csum_d  = csum_q ^ rd_data_i[7:0] ^ rd_data_i[15:8]
                         ^ rd_data_i[23:16] ^ rd_data_i[31:24];
`endif
        state_d = S_START;
      end
      S_START: begin
        tx_o  = 1'b0;
        tmr_d = tmr_next;
        if (bit_end) begin
          bit_d   = 4'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_o  = word_q[bit_q[2:0]];
        tmr_d = tmr_next;
        if (bit_end) begin
          if (bit_q == 4'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 4'd1;
        end
      end
      S_STOP: begin
        tmr_d = tmr_next;
        if (bit_end) begin
          if (idx_q != 2'd3) begin
            word_d  = {8'h00, word_q[31:8]};
            idx_d   = idx_q + 2'd1;
            state_d = S_START;
          end else if (cnt_q > CNT_WIDTH'(1)) begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            cnt_d   = cnt_q - CNT_WIDTH'(1);
            state_d = S_READ;
          end else begin
`ifdef ICCM_DUMP_CHECKSUM_EN
            bit_d   = 4'd0;
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef ICCM_DUMP_CHECKSUM_EN
      // Whole checksum frame lives here: slot 0 start, 1..8 data, 9 stop.
      S_CSUM: begin
        if (bit_q == 4'd0)      tx_o = 1'b0;
        else if (bit_q == 4'd9) tx_o = 1'b1;
        else                    tx_o = csum_q[csum_sel];
        tmr_d = tmr_next;
        if (bit_end) begin
          if (bit_q == 4'd9) state_d = S_DONE;
          else               bit_d   = bit_q + 4'd1;
        end
      end
`endif
      S_DONE: begin
        busy_o  = 1'b0;
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      cpb_q   <= 16'd1;
      tmr_q   <= 16'd0;
      bit_q   <= 4'd0;
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      cpb_q   <= cpb_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

`ifdef ICCM_DUMP_CHECKSUM_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) csum_q <= 8'h00;
    else       csum_q <= csum_d;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_iccm_dump_tx.sv
`default_nettype none
// ==========================================================================
// Module : tb_iccm_dump_tx
// Scoreboard bench for iccm_dump_tx: UART decoder, read and done monitors.
// Rev    : 1.0
// ==========================================================================
module tb_iccm_dump_tx;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [11:0] start_addr_i = '0;
  logic [12:0] word_cnt_i = '0;
  logic [15:0] clks_per_bit_i = '0;
  logic        rd_en_o;
  logic [11:0] rd_addr_o;
  logic [31:0] rd_data_i = '0;
  logic        tx_o, busy_o, done_o;

  iccm_dump_tx #(.ADDR_WIDTH(12), .CNT_WIDTH(13)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .start_addr_i(start_addr_i), .word_cnt_i(word_cnt_i),
    .clks_per_bit_i(clks_per_bit_i), .rd_en_o(rd_en_o),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .tx_o(tx_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; int unsigned c; } frame_t;
  typedef struct { logic [11:0] a; int unsigned c; } rd_t;

  frame_t      exp_frames[$];
  rd_t         exp_rd[$];
  int unsigned exp_done[$];

  logic [31:0] mem [0:4095];
  int unsigned cyc = 0;
  int unsigned mon_cpb = 1;
  int unsigned last_c0 = 0;
  int          tests = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  task automatic check(input bit ok, input string name,
                       input longint unsigned act, input longint unsigned req);
    tests++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: cycle c0 is the first cycle after the accepted start edge.
  task automatic start_dump(input logic [11:0] a, input logic [12:0] n, input logic [15:0] cpb);
    int unsigned e, wbase;
    logic [31:0] d;
    logic [11:0] wa;
    logic [7:0]  x;
    @(negedge clk);
    start_addr_i = a; word_cnt_i = n; clks_per_bit_i = cpb; start_i = 1'b1;
    e = (cpb == 16'd0) ? 1 : int'(cpb);
    mon_cpb = e;
    @(posedge clk); #1;
    start_i = 1'b0;
    last_c0 = cyc;
    start_addr_i = 12'($urandom); word_cnt_i = 13'($urandom); clks_per_bit_i = 16'($urandom);
    x = 8'h00;
    if (n == 13'd0) begin
      exp_done.push_back(last_c0);
      check(busy_o == 1'b0, "count0_busy", busy_o, 0);
      check(tx_o == 1'b1, "count0_tx", tx_o, 1);
    end else begin
      for (int w = 0; w < int'(n); w++) begin
        wa = a + 12'(w);
        wbase = last_c0 + w * (40 * e + 2);
        exp_rd.push_back('{wa, wbase});
        d = mem[wa];
        for (int j = 0; j < 4; j++) begin
          exp_frames.push_back('{d[8*j +: 8], wbase + 2 + j * 10 * e});
          x ^= d[8*j +: 8];
        end
      end
`ifdef ICCM_DUMP_CHECKSUM_EN
      exp_frames.push_back('{x, last_c0 + 2 + n * 40 * e + (n - 1) * 2});
      exp_done.push_back(last_c0 + 2 + n * 40 * e + (n - 1) * 2 + 10 * e);
`else
      exp_done.push_back(last_c0 + 2 + n * 40 * e + (n - 1) * 2);
`endif
    end
  endtask

  task automatic wait_idle(input int unsigned bound);
    int unsigned k;
    k = 0;
    while (exp_done.size() != 0 && k < bound) begin
      @(negedge clk); #1;
      k++;
    end
    if (exp_done.size() != 0) begin
      check(1'b0, "done_timeout", exp_done.size(), 0);
      exp_done.delete(); exp_frames.delete(); exp_rd.delete();
    end else begin
      check(exp_frames.size() == 0, "frames_drained", exp_frames.size(), 0);
      check(exp_rd.size() == 0, "reads_drained", exp_rd.size(), 0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cycle(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: decodes tx_o, checks reads and done against the queues.
  initial begin : monitor
    frame_t      fe;
    rd_t         re;
    int unsigned de, off, mst;
    logic [7:0]  mb;
    bit          act, unexp;
    act = 1'b0; unexp = 1'b0; mst = 0; mb = '0; fe = '{8'h00, 0};
    forever begin
      @(negedge clk);
      if (rst_i) begin
        act = 1'b0;
      end else begin
        if (rd_en_o) begin
          if (exp_rd.size() == 0) check(1'b0, "unexpected_rd", rd_addr_o, 0);
          else begin
            re = exp_rd.pop_front();
            check(rd_addr_o == re.a, "rd_addr", rd_addr_o, re.a);
            check(cyc == re.c && busy_o, "rd_cycle", cyc, re.c);
          end
        end
        if (done_o) begin
          if (exp_done.size() == 0) check(1'b0, "unexpected_done", cyc, 0);
          else begin
            de = exp_done.pop_front();
            check(cyc == de, "done_cycle", cyc, de);
            check(busy_o == 1'b0, "busy_at_done", busy_o, 0);
          end
        end
        if (!act) begin
          if (tx_o == 1'b0) begin
            act = 1'b1; mst = cyc; mb = '0;
            if (exp_frames.size() == 0) begin
              unexp = 1'b1;
              check(1'b0, "unexpected_frame", cyc, 0);
            end else begin
              unexp = 1'b0;
              fe = exp_frames.pop_front();
              check(cyc == fe.c, "frame_start", cyc, fe.c);
            end
          end
        end else begin
          off = cyc - mst;
          for (int k = 1; k <= 8; k++)
            if (off == k * mon_cpb + mon_cpb / 2) mb[k-1] = tx_o;
          if (off == 9 * mon_cpb + mon_cpb / 2) begin
            check(tx_o == 1'b1, "stop_bit", tx_o, 1);
            if (!unexp) check(mb == fe.b, "frame_byte", mb, fe.b);
            act = 1'b0;
          end
        end
      end
    end
  end

  initial begin : driver
    logic [11:0] a;
    logic [12:0] n;
    logic [15:0] c;
    int unsigned e;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[12'h010] = 32'hDEADBEEF;

    repeat (2) @(negedge clk);
    check(tx_o == 1'b1, "reset_tx", tx_o, 1);
    check(rd_en_o == 1'b0, "reset_rd_en", rd_en_o, 0);
    check(rd_addr_o == 12'h000, "reset_rd_addr", rd_addr_o, 0);
    check(busy_o == 1'b0, "reset_busy", busy_o, 0);
    check(done_o == 1'b0, "reset_done", done_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    // Single word, known pattern; done must land at c0+162 (N+163).
    start_dump(12'h010, 13'd1, 16'd4);
    check(exp_done[0] == last_c0 + 162, "single_done_model", exp_done[0], last_c0 + 162);
    wait_idle(400);

    // Address wrap across two words.
    start_dump(12'hFFF, 13'd2, 16'd2);
    wait_idle(400);

    // Zero count.
    start_dump(12'h123, 13'd0, 16'd3);
    wait_idle(20);

    // Start while busy, inside the third byte.
    start_dump(12'h100, 13'd2, 16'd3);
    wait_cycle(last_c0 + 2 + 2 * 30 + 5);
    @(negedge clk);
    start_addr_i = 12'($urandom); word_cnt_i = 13'd3; clks_per_bit_i = 16'd1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_idle(400);

    // Asynchronous reset during data bit 4 of the first byte.
    start_dump(12'h200, 13'd2, 16'd4);
    wait_cycle(last_c0 + 2 + 5 * 4 + 1);
    #1 rst_i = 1'b1;
    #1;
    check(tx_o == 1'b1, "rst_mid_tx", tx_o, 1);
    check(busy_o == 1'b0, "rst_mid_busy", busy_o, 0);
    check(rd_en_o == 1'b0, "rst_mid_rd_en", rd_en_o, 0);
    exp_frames.delete(); exp_rd.delete(); exp_done.delete();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    start_dump(12'h300, 13'd1, 16'd2);
    wait_idle(200);

    // Randomized dumps, half of them near the top of the address space.
    for (int t = 0; t < 12; t++) begin
      a = (t % 2 == 0) ? 12'hFFD + 12'($urandom_range(0, 2)) : 12'($urandom);
      n = 13'($urandom_range(0, 3));
      c = 16'($urandom_range(0, 3));
      e = (c == 16'd0) ? 1 : int'(c);
      start_dump(a, n, c);
      wait_idle(3 + n * 50 * e + 2 * n + 20);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
